// File: rtl/lvds_7to1_frame_checker.sv
// 7:1 LVDS frame checker: aligns to the clock-lane pattern and verifies each data lane carries
// a 7-bit incrementing count. Optional error counter is built when LVDS_CHK_ERR_CNT_EN is defined.
module lvds_7to1_frame_checker #(
  parameter int         LANES       = 5,
  parameter logic [6:0] CLK_PATTERN = 7'b1100011,
  parameter int         LOCK_FRAMES = 4,
  parameter int         CNT_W       = 16
) (
  input  logic               clk_1x,
  input  logic               reset_n,
  input  logic               clkin,
  input  logic [LANES-1:0]   datain,
  input  logic               clear_err,
  output logic               locked,
  output logic               frame_valid,
  output logic [7*LANES-1:0] frame_data,
  output logic [LANES-1:0]   match,
  output logic               all_match,
  output logic [CNT_W-1:0]   err_count
);

  typedef enum logic [1:0] {HUNT = 2'd0, SYNC = 2'd1, LOCKED = 2'd2} state_t;
  localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

  state_t             r_state, w_state_nxt;
  logic [6:0]         r_clk_sr;
  logic [7*LANES-1:0] r_lane_sr, r_prev, r_frame_data;
  logic [2:0]         r_phase, w_phase_nxt;
  logic [3:0]         r_good, w_good_nxt;
  logic [LANES-1:0]   r_match, w_match_calc, w_match_nxt;
  logic               r_locked, r_frame_valid, r_all_match;
  logic               w_bnd, w_accept, w_drop, w_hunt_bnd, w_locked_nxt, w_emit;

  assign w_bnd = (r_clk_sr == CLK_PATTERN);

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_match_calc[i] = (r_lane_sr[7*i +: 7] == 7'(r_prev[7*i +: 7] + 7'd1));
    end
  end

  // Phase 6 is the only slot where a boundary may legally appear once aligned.
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = 3'd0;
    w_good_nxt  = r_good;
    w_accept    = 1'b0;
    w_drop      = 1'b0;
    w_hunt_bnd  = 1'b0;
    case (r_state)
      HUNT: begin
        if (w_bnd) begin
          w_hunt_bnd  = 1'b1;
          w_good_nxt  = 4'd1;
          w_state_nxt = (LOCK_N == 4'd1) ? LOCKED : SYNC;
        end else begin
          w_good_nxt = 4'd0;
        end
      end
      SYNC, LOCKED: begin
        if (w_bnd && (r_phase == 3'd6)) begin
          w_accept = 1'b1;
          if (r_state == SYNC) begin
            w_good_nxt = r_good + 4'd1;
            if ((r_good + 4'd1) >= LOCK_N) begin
              w_state_nxt = LOCKED;
            end else begin
              w_state_nxt = SYNC;
            end
          end else begin
            w_state_nxt = LOCKED;
          end
        end else if (w_bnd || (r_phase == 3'd6)) begin
          w_drop      = 1'b1;
          w_good_nxt  = 4'd0;
          w_state_nxt = HUNT;
        end else begin
          w_phase_nxt = r_phase + 3'd1;
        end
      end
      default: begin
        w_state_nxt = HUNT;
        w_good_nxt  = 4'd0;
      end
    endcase
    w_locked_nxt = (w_state_nxt == LOCKED);
    w_emit       = w_accept && (r_state == LOCKED);
    if (w_accept) begin
      w_match_nxt = w_match_calc;
    end else if (w_drop) begin
      w_match_nxt = '0;
    end else begin
      w_match_nxt = r_match;
    end
  end

  always_ff @(posedge clk_1x) begin
    if (!reset_n) begin
      r_state <= HUNT;
      r_phase <= 3'd0;
      r_good  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_good  <= w_good_nxt;
    end
  end

  // Deserialisers, reference words and registered outputs.
  always_ff @(posedge clk_1x) begin
    if (!reset_n) begin
      r_clk_sr      <= 7'd0;
      r_lane_sr     <= '0;
      r_prev        <= '0;
      r_frame_data  <= '0;
      r_match       <= '0;
      r_locked      <= 1'b0;
      r_frame_valid <= 1'b0;
      r_all_match   <= 1'b0;
    end else begin
      r_clk_sr <= {clkin, r_clk_sr[6:1]};
      for (int i = 0; i < LANES; i++) begin
        r_lane_sr[7*i +: 7] <= {datain[i], r_lane_sr[7*i+1 +: 6]};
      end
      if (w_accept || w_hunt_bnd) begin
        r_prev <= r_lane_sr;
      end
      if (w_emit) begin
        r_frame_data <= r_lane_sr;
      end
      r_match       <= w_match_nxt;
      r_locked      <= w_locked_nxt;
      r_frame_valid <= w_emit;
      r_all_match   <= w_locked_nxt && (&w_match_nxt);
    end
  end

  assign locked      = r_locked;
  assign frame_valid = r_frame_valid;
  assign frame_data  = r_frame_data;
  assign match       = r_match;
  assign all_match   = r_all_match;

`ifdef LVDS_CHK_ERR_CNT_EN
  logic [CNT_W-1:0] r_err_count;
  logic             w_err_inc;

  assign w_err_inc = (r_state == LOCKED) && ((w_accept && !(&w_match_calc)) || w_drop);

  // Saturating error count; clear has priority over a same-cycle increment.
  always_ff @(posedge clk_1x) begin
    if (!reset_n) begin
      r_err_count <= '0;
    end else if (clear_err) begin
      r_err_count <= '0;
    end else if (w_err_inc && !(&r_err_count)) begin
      r_err_count <= r_err_count + CNT_W'(1);
    end
  end

  assign err_count = r_err_count;
`else
  logic w_unused_clear;
  assign w_unused_clear = clear_err;
  assign err_count      = '0;
`endif

endmodule

// File: doc/lvds_7to1_frame_checker.md
LVDS_7TO1_FRAME_CHECKER -- requirements
Module: lvds_7to1_frame_checker

Interface
REQ-001 SHALL have parameter LANES, default 5: number of 7:1 data lanes checked.
REQ-002 SHALL have parameter CLK_PATTERN, default 7'b1100011: clock-lane word marking a frame boundary.
REQ-003 SHALL have parameter LOCK_FRAMES, default 4: number of consecutive correctly spaced boundaries needed to reach LOCKED (range 1..15).
REQ-004 SHALL have parameter CNT_W, default 16: width of the error counter.
REQ-005 SHALL have port clk_1x, input, 1: bit-rate clock, single clock domain; all logic on rising edge.
REQ-006 SHALL have port reset_n, input, 1: reset, synchronous, active-low.
REQ-007 SHALL have port clkin, input, 1: serial clock-lane bit, one bit per clk_1x.
REQ-008 SHALL have port datain, input, LANES: serial data bits, one per lane per clk_1x.
REQ-009 SHALL have port clear_err, input, 1: synchronous clear of err_count.
REQ-010 SHALL have port locked, output, 1: frame alignment achieved.
REQ-011 SHALL have port frame_valid, output, 1: one-cycle pulse per accepted frame while locked.
REQ-012 SHALL have port frame_data, output, 7*LANES: lane i word on bits [7i+6:7i].
REQ-013 SHALL have port match, output, LANES: per-lane result of the last increment check.
REQ-014 SHALL have port all_match, output, 1: locked AND every bit of match set.
REQ-015 SHALL have port err_count, output, CNT_W: saturating frame-error count.

Function
REQ-016 SHALL shift every clk_1x: clock shift register <= {clkin, clock register[6:1]}; each lane register likewise with datain[i]. First-received bit ends in bit 0.
REQ-017 SHALL define boundary as clock shift register == CLK_PATTERN, evaluated on registered values; all outputs registered, so frame_valid rises 2 edges after the 7th clock-word bit is presented.
REQ-018 SHALL implement FSM HUNT, SYNC, LOCKED with a 3-bit phase counter 0..6 that restarts at 0 on every accepted boundary.
REQ-019 HUNT: on boundary -> SYNC, good count = 1, lane words stored as previous; no check made.
REQ-020 SYNC/LOCKED: a boundary is expected exactly when phase == 6; boundary at phase 6 is accepted; boundary at any other phase, or no boundary at phase 6, -> HUNT.
REQ-021 SYNC: each accepted boundary increments good count; when it reaches LOCK_FRAMES -> LOCKED (locked high the following cycle). With LOCK_FRAMES = 1, HUNT boundary goes directly to LOCKED.
REQ-022 At each accepted boundary SHALL set match[i] = (lane word i == previous word i + 1, modulo 128, 7-bit wraparound so 7'h7F -> 7'h00 passes), then store current words as previous.
REQ-023 LOCKED: each accepted boundary SHALL pulse frame_valid for one cycle, with frame_data holding the checked words until the next pulse.
REQ-024 Entering HUNT SHALL clear match, locked, good count, and phase in the same edge.
REQ-025 err_count SHALL increment by 1 per accepted LOCKED boundary with any lane mismatch (once per frame, not per lane), and by 1 on each LOCKED -> HUNT transition.
REQ-026 err_count SHALL saturate at all-ones; clear_err sets it to 0 and wins over a simultaneous increment.

Reset
REQ-027 reset_n low at a clk_1x edge SHALL force HUNT and clear all shift registers, previous words, counters and outputs (locked, frame_valid, frame_data, match, all_match, err_count = 0), including mid-frame or while LOCKED.
REQ-028 The first frame after reset release SHALL be treated as in HUNT; no error counted.

Configuration
REQ-029 Macro LVDS_CHK_ERR_CNT_EN defined: err_count logic per REQ-025/026 is built.
REQ-030 LVDS_CHK_ERR_CNT_EN undefined: no counter register; err_count tied to 0, clear_err ignored; all other behaviour unchanged.

Verification
REQ-031 LANES=5, clock lane 1100011, lanes start 1..5 incrementing every 7 bits -> locked high after 4 boundaries, match=5'b11111, all_match=1, err_count=0 over 1000 frames incl. 7F->00 wrap.
REQ-032 Flip one bit of lane 2 in frame 10 after lock -> match[2]=0 for frames 10 and 11, locked stays high, err_count=2.
REQ-033 Insert one extra clk_1x bit (slip) on all lanes after lock -> HUNT, locked low next edge, err_count+1; relock after LOCK_FRAMES frames.
REQ-034 CNT_W=4, corrupt lane 0 every frame for 20 frames -> err_count holds 15; clear_err pulse with concurrent error -> 0.
REQ-035 reset_n low 1 cycle while LOCKED -> all outputs 0 next edge; relock requires fresh 4 boundaries.
REQ-036 Build without LVDS_CHK_ERR_CNT_EN, repeat REQ-032 -> err_count=0, match behaviour identical.
